lsu_apb_master: RTL and testbench

//  Load/store unit for the MEM stage. Turns one pipeline load/store request into one APB

---
 rtl/lsu_apb_master.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_apb_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_apb_master.sv
// lsu_apb_master: MEM-stage load/store unit driving one APB transfer per request.
// Store data is lane-replicated with matching strobes; load data is lane-shifted
// and sign/zero-extended before it is returned.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses
// with an error instead of silently aligning them down.

// Per-byte-lane store strobe and store data select.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,      // 00 B, 01 H, 10 W
  input  logic [1:0] lane_sel,  // addr[1:0]
  input  logic [7:0] b_byte,    // wdata[7:0]
  input  logic [7:0] h_byte,    // halfword byte that lands on this lane
  input  logic [7:0] w_byte,    // word byte that lands on this lane
  output logic       strb,
  output logic [7:0] wbyte
);
  localparam logic [1:0] L = 2'(LANE);

  // Decode strobe and replicated data byte from access size
  always_comb begin
    strb  = 1'b0;
    wbyte = w_byte;
    case (size)
      2'b00: begin strb = (lane_sel == L);       wbyte = b_byte; end
      2'b01: begin strb = (lane_sel[1] == L[1]); wbyte = h_byte; end
      2'b10: strb = 1'b1;
      default: ;
    endcase
  end
endmodule

module lsu_apb_master #(
  parameter int ADDR_W   = 11,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [31:0]       pwdata_o,
  output logic [3:0]        pstrb_o,
  output logic [2:0]        sel_mod_o,
  input  logic [31:0]       prdata_i,
  input  logic              pready_i
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t                         state_q, state_d;
  req_t                           req_q;
  logic [CNT_W-1:0]               cnt_q;
  logic                           err_q;
  logic [31:0]                    rdata_q;
  logic                           req_illegal;
  logic                           timeout;
  logic [1:0]                     shift;
  logic [31:0]                    shifted;
  logic [31:0]                    load_data;
  logic [NUM_LANES-1:0]           lane_strb;
  logic [NUM_LANES-1:0][7:0]      lane_wdata;

  // Requests that never reach the bus: bad size, outside the memory window,
  // and (optionally) misaligned halfword/word accesses
  always_comb begin
    req_illegal = (&req_funct3_i[1:0]) || (|req_addr_i[31:ADDR_W]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
        (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00))
      req_illegal = 1'b1;
`endif
  end

  // Abort when the ACCESS wait count would reach WAIT_MAX this cycle
  assign timeout = (WAIT_MAX != 0) && !pready_i && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    stall_o     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        stall_o     = req_valid_i;
        if (req_valid_i) state_d = req_illegal ? RESP : SETUP;
      end
      SETUP: begin
        psel_o  = 1'b1;
        stall_o = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        stall_o   = 1'b1;
        if (pready_i || timeout) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter, error flag and load-data register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          req_q   <= '{we: req_we_i, funct3: req_funct3_i,
                       addr: req_addr_i[ADDR_W-1:0], wdata: req_wdata_i};
          err_q   <= req_illegal;
          rdata_q <= '0;
          cnt_q   <= '0;
        end
        ACCESS: begin
          if (pready_i)     rdata_q <= req_q.we ? 32'h0 : load_data;
          else if (timeout) err_q   <= 1'b1;
          else              cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Load path: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shift = 2'b00;
    case (req_q.funct3[1:0])
      2'b00:   shift = req_q.addr[1:0];
      2'b01:   shift = {req_q.addr[1], 1'b0};
      default: ;
    endcase
    shifted = prdata_i >> {shift, 3'b000};
    case (req_q.funct3[1:0])
      2'b00:   load_data = req_q.funct3[2] ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = req_q.funct3[2] ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .size     (req_q.funct3[1:0]),
      .lane_sel (req_q.addr[1:0]),
      .b_byte   (req_q.wdata[7:0]),
      .h_byte   (req_q.wdata[8*(i%2) +: 8]),
      .w_byte   (req_q.wdata[8*i +: 8]),
      .strb     (lane_strb[i]),
      .wbyte    (lane_wdata[i])
    );
  end

  // Bus fields come straight from the captured request, so they hold
  // steady for the whole SETUP/ACCESS window
  assign paddr_o     = {req_q.addr[ADDR_W-1:2], 2'b00};
  assign pwrite_o    = req_q.we;
  assign pwdata_o    = lane_wdata;
  assign pstrb_o     = req_q.we ? lane_strb : 4'b0000;
  assign sel_mod_o   = 3'b010;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q && (state_q == RESP);
endmodule

// File: tb/tb_lsu_apb_master.sv
// Bench for lsu_apb_master: APB memory model, table-driven request vectors,
// scoreboard of expected responses, plus wait-state, timeout and reset sequences.
module tb_lsu_apb_master;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        stall_o;
  logic [10:0] paddr_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  sel_mod_o;
  logic [31:0] prdata_i;
  logic        pready_i;

  lsu_apb_master #(.ADDR_W(11), .WAIT_MAX(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .stall_o(stall_o), .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .sel_mod_o(sel_mod_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk_i = ~clk_i;

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // APB memory slave with programmable wait states
  logic [31:0] mem [0:511];
  int  acc_cnt = 0;
  int  wait_n = 0;
  bit  stuck = 1'b0;

  assign pready_i = !stuck && (acc_cnt >= wait_n);
  assign prdata_i = mem[paddr_o[10:2]];

  always @(posedge clk_i) begin
    if (psel_o && penable_o && !pready_i) acc_cnt <= acc_cnt + 1;
    else                                  acc_cnt <= 0;
  end

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (psel_o && penable_o && pready_i && pwrite_o) begin
      for (int b = 0; b < 4; b++)
        if (pstrb_o[b]) mem[paddr_o[10:2]][8*b +: 8] <= pwdata_o[8*b +: 8];
    end
  end

  // Scoreboard: expected responses queued at issue, checked on rsp_valid_o
  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sbq[$];

  always @(negedge clk_i) begin : mon
    exp_t e;
    if (rst_ni && rsp_valid_o) begin
      if (sbq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] pwdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  // Issue one request and check timing, bus phases and bus field stability
  task automatic do_req(input vec_t v);
    int cyc, pc, ec, sc, unstable;
    bit got;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic        w0;
    a0 = '0; d0 = '0; s0 = '0; w0 = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_we_i = v.we; req_funct3_i = v.f3;
    req_addr_i = v.addr; req_wdata_i = v.wdata;
    sbq.push_back('{rdata: v.rdata, err: v.err});
    @(negedge clk_i);
    chk("req_ready", 32'(req_ready_o), 32'd1);
    chk("stall_idle", 32'(stall_o), 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0; req_addr_i = '0; req_wdata_i = '0;
    cyc = 0; got = 1'b0; pc = 0; ec = 0; sc = 0; unstable = 0;
    while (!got && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      if (rsp_valid_o) got = 1'b1;
      if (psel_o) pc++;
      if (penable_o) ec++;
      if (stall_o) sc++;
      if (cyc == 1 && v.lat > 1) begin
        chk("setup_phase", {30'd0, psel_o, penable_o}, 32'd2);
        chk("paddr", 32'(paddr_o), v.addr & 32'h7FC);
        chk("pstrb", 32'(pstrb_o), 32'(v.strb));
        chk("pwdata", pwdata_o, v.pwdata);
        chk("pwrite", 32'(pwrite_o), 32'(v.we));
        a0 = 32'(paddr_o); d0 = pwdata_o; s0 = pstrb_o; w0 = pwrite_o;
      end else if (psel_o && (32'(paddr_o) != a0 || pwdata_o != d0 ||
                              pstrb_o != s0 || pwrite_o != w0)) begin
        unstable++;
      end
    end
    chk("latency", 32'(cyc), 32'(v.lat));
    chk("psel_cycles", 32'(pc), 32'((v.lat > 1) ? v.lat - 1 : 0));
    chk("penable_cycles", 32'(ec), 32'((v.lat > 1) ? v.lat - 2 : 0));
    chk("stall_cycles", 32'(sc), 32'((v.lat > 1) ? v.lat - 1 : 0));
    if (v.lat > 1) chk("apb_stable", 32'(unstable), 32'd0);
    @(negedge clk_i);
    chk("rsp_one_pulse", 32'(rsp_valid_o), 32'd0);
    chk("ready_after", 32'(req_ready_o), 32'd1);
  endtask

  vec_t vt[15];
  vec_t hv;
  int   rspseen;

  initial begin
    vt[0]  = '{1'b1, 3'b000, 32'h13,  32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0, 3};
    vt[1]  = '{1'b1, 3'b010, 32'h10,  32'h80F07F81, 4'b1111, 32'h80F07F81, 32'h0,        1'b0, 3};
    vt[2]  = '{1'b0, 3'b000, 32'h10,  32'h0,        4'b0000, 32'h0,        32'hFFFFFF81, 1'b0, 3};
    vt[3]  = '{1'b0, 3'b100, 32'h11,  32'h0,        4'b0000, 32'h0,        32'h0000007F, 1'b0, 3};
    vt[4]  = '{1'b0, 3'b001, 32'h12,  32'h0,        4'b0000, 32'h0,        32'hFFFF80F0, 1'b0, 3};
    vt[5]  = '{1'b0, 3'b101, 32'h12,  32'h0,        4'b0000, 32'h0,        32'h000080F0, 1'b0, 3};
    vt[6]  = '{1'b0, 3'b010, 32'h10,  32'h0,        4'b0000, 32'h0,        32'h80F07F81, 1'b0, 3};
    vt[7]  = '{1'b1, 3'b001, 32'h22,  32'h1234BEEF, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 3};
    vt[8]  = '{1'b1, 3'b000, 32'h20,  32'h0000007C, 4'b0001, 32'h7C7C7C7C, 32'h0,        1'b0, 3};
    vt[9]  = '{1'b0, 3'b010, 32'h20,  32'h0,        4'b0000, 32'h0,        32'hBEEF007C, 1'b0, 3};
    vt[10] = '{1'b0, 3'b000, 32'h23,  32'h0,        4'b0000, 32'h0,        32'hFFFFFFBE, 1'b0, 3};
    vt[11] = '{1'b0, 3'b011, 32'h10,  32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};
    vt[12] = '{1'b0, 3'b010, 32'h800, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};
`ifdef LSU_MISALIGN_TRAP_EN
    vt[13] = '{1'b0, 3'b001, 32'h21,  32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};
`else
    vt[13] = '{1'b0, 3'b001, 32'h21,  32'h0,        4'b0000, 32'h0,        32'h0000007C, 1'b0, 3};
`endif
    vt[14] = '{1'b1, 3'b000, 32'h800, 32'h000000EE, 4'b0000, 32'h0,        32'h0,        1'b1, 1};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_psel", {30'd0, psel_o, penable_o}, 32'd0);
    chk("rst_pwrite", 32'(pwrite_o), 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_paddr", 32'(paddr_o), 32'd0);
    chk("rst_pstrb", 32'(pstrb_o), 32'd0);
    chk("rst_pwdata", pwdata_o, 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("sel_mod", 32'(sel_mod_o), 32'd2);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 15; i++) do_req(vt[i]);

    // Three wait states: stall for SETUP + 4 ACCESS cycles, response in cycle 6
    wait_n = 3;
    hv = '{1'b0, 3'b010, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h80F07F81, 1'b0, 6};
    do_req(hv);
    wait_n = 0;

    // Stuck slave: abort after 15 ACCESS cycles with an error
    stuck = 1'b1;
    hv = '{1'b0, 3'b010, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 17};
    do_req(hv);
    stuck = 1'b0;
    hv = '{1'b0, 3'b100, 32'h13, 32'h0, 4'b0000, 32'h0, 32'h00000080, 1'b0, 3};
    do_req(hv);

    // Reset in the middle of ACCESS drops the transfer without a response
    stuck = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h10;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_funct3_i = '0; req_addr_i = '0;
    @(posedge clk_i); #2;
    chk("pre_rst_access", {30'd0, psel_o, penable_o}, 32'd3);
    rst_ni = 1'b0;
    #1;
    chk("rst_async_psel", {30'd0, psel_o, penable_o}, 32'd0);
    chk("rst_async_stall", 32'(stall_o), 32'd0);
    chk("rst_async_ready", 32'(req_ready_o), 32'd1);
    rspseen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (rsp_valid_o) rspseen++;
    end
    stuck = 1'b0;
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      if (rsp_valid_o) rspseen++;
    end
    chk("no_rsp_after_rst", 32'(rspseen), 32'd0);
    hv = '{1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 3};
    do_req(hv);
    hv = '{1'b0, 3'b010, 32'h40, 32'h0, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 3};
    do_req(hv);
    hv = '{1'b0, 3'b101, 32'h42, 32'h0, 4'b0000, 32'h0, 32'h0000CAFE, 1'b0, 3};
    do_req(hv);

    repeat (3) @(negedge clk_i);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
